// File: rtl/spi_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the SPI slave transmit path.
// Adds occupancy, sticky overflow/underflow flags and a chip-select flush.
module spi_tx_fifo #(
    parameter int unsigned           DATA_W    = 8,
    parameter int unsigned           ADDR_W    = 4,
    parameter logic [DATA_W-1:0]     IDLE_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_flags
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FullCnt   = (ADDR_W + 1)'(Depth);
    localparam logic [ADDR_W:0] AlmostCnt = (ADDR_W + 1)'(Depth - 2);

    logic [DATA_W-1:0] mem [Depth];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, almost_full_q, out_valid_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              pop, push;

    // Flush masks both handshakes so nothing moves and no flag is set.
    assign pop  = ~flush & out_valid_q & out_ready;
    assign push = ~flush & wr_en & (~full_q | pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            // A set condition outranks a same-cycle clear.
            if (wr_en && full_q && !pop) overflow_d = 1'b1;
            else if (clear_flags) overflow_d = 1'b0;
            if (out_ready && !out_valid_q) underflow_d = 1'b1;
            else if (clear_flags) underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            out_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= (count_d == FullCnt);
            almost_full_q <= (count_d >= AlmostCnt);
            out_valid_q   <= (count_d != '0);
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // Storage has no reset; contents are only visible while out_valid is set.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign count       = count_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_valid_q ? mem[rd_ptr_q] : IDLE_WORD;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Self-checking bench for spi_tx_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_spi_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, wr_en, out_ready, clear_flags;
    logic [7:0] wr_data;
    logic       full, almost_full, out_valid, overflow, underflow;
    logic [4:0] count;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] mq[$];
    logic       m_ovf, m_unf;

    spi_tx_fifo #(
        .DATA_W    (8),
        .ADDR_W    (4),
        .IDLE_WORD (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .underflow   (underflow),
        .clear_flags (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("count", 32'(count), 32'(mq.size()));
        check("full", 32'(full), 32'(mq.size() == 16));
        check("almost_full", 32'(almost_full), 32'(mq.size() >= 14));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("out_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h00);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input logic fl, input logic we, input logic [7:0] wd,
                         input logic rdy, input logic cf);
        bit was_empty, was_full, do_pop, do_push;
        flush = fl; wr_en = we; wr_data = wd; out_ready = rdy; clear_flags = cf;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_empty = (mq.size() == 0);
            was_full  = (mq.size() == 16);
            do_pop    = !was_empty && rdy;
            do_push   = we && (!was_full || do_pop);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(wd);
            if (we && was_full && !do_pop) m_ovf = 1'b1;
            else if (cf) m_ovf = 1'b0;
            if (rdy && was_empty) m_unf = 1'b1;
            else if (cf) m_unf = 1'b0;
        end
        check_all();
        flush = 0; wr_en = 0; out_ready = 0; clear_flags = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 0; wr_en = 0; wr_data = 0; out_ready = 0; clear_flags = 0;
        m_ovf = 0; m_unf = 0;
        #12 rst_n = 1'b1;
        check_all();

        // Two pushes then one pop.
        cycle(0, 1, 8'hA5, 0, 0);
        cycle(0, 1, 8'h3C, 0, 0);
        check("s1_count", 32'(count), 32'd2);
        check("s1_head", 32'(out_data), 32'hA5);
        cycle(0, 0, 8'h00, 1, 0);
        check("s1_pop", 32'(out_data), 32'h3C);

        // Fill, overflow, drain in order.
        cycle(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 8'(i), 0, 0);
            if (i == 12) check("s2_af_low", 32'(almost_full), 32'd0);
            if (i == 13) check("s2_af_14", 32'(almost_full), 32'd1);
        end
        check("s2_full", 32'(full), 32'd1);
        cycle(0, 1, 8'hFF, 0, 0);
        check("s2_ovf", 32'(overflow), 32'd1);
        check("s2_cnt", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("s2_order", 32'(out_data), 32'(i));
            cycle(0, 0, 8'h00, 1, 0);
        end

        // Full with simultaneous push/pop across pointer wrap.
        cycle(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            check("s3_seq", 32'(out_data), (i < 16) ? 32'(i) : 32'h80);
            cycle(0, 1, 8'h80, 1, 0);
        end
        check("s3_ovf", 32'(overflow), 32'd0);
        check("s3_cnt", 32'(count), 32'd16);

        // Underflow then clear.
        cycle(1, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 1, 0);
        check("s4_unf", 32'(underflow), 32'd1);
        check("s4_idle", 32'(out_data), 32'h00);
        cycle(0, 0, 8'h00, 0, 1);
        check("s4_clr", 32'(underflow), 32'd0);

        // Flush with concurrent push/pop.
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h20 + i), 0, 0);
        cycle(1, 1, 8'h77, 1, 0);
        check("s5_cnt", 32'(count), 32'd0);
        check("s5_valid", 32'(out_valid), 32'd0);
        cycle(0, 1, 8'h11, 0, 0);
        check("s5_head", 32'(out_data), 32'h11);

        // Asynchronous reset between edges with count 9 and overflow set.
        cycle(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(8'h50 + i), 0, 0);
        cycle(0, 1, 8'hFF, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 8'h00, 1, 0);
        check("s6_pre_cnt", 32'(count), 32'd9);
        check("s6_pre_ovf", 32'(overflow), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        mq.delete(); m_ovf = 0; m_unf = 0;
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 1, 8'h42, 0, 0);
        check("s6_head", 32'(out_data), 32'h42);
        check("s6_cnt", 32'(count), 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 99) < 60),
                  8'($urandom),
                  ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/spi_tx_fifo.md
Name: spi_tx_fifo

Overview:
- Synchronous first-word-fall-through byte FIFO that sits directly upstream of the SPI slave's transmit path.
- Application logic pushes response bytes at its own pace.
- The SPI slave pops one byte whenever its single-entry transmit queue is free.
- Adds occupancy reporting, sticky overflow/underflow flags and a flush tied to chip-select assertion, so stale bytes never leak into a new transaction.

Parameters:
- DATA_W, 8, width of each stored word in bits.
- ADDR_W, 4, log2 of depth; depth = 2**ADDR_W = 16 entries.
- IDLE_WORD, 8'h00, value driven on out_data while the FIFO is empty.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents and flags (driven by SSEL falling-edge detect).
- wr_en  in  1  push request.
- wr_data  in  DATA_W  push data.
- full  out  1  no free entry.
- almost_full  out  1  count >= depth-2.
- count  out  ADDR_W+1  current occupancy, 0..depth.
- out_valid  out  1  head word available.
- out_data  out  DATA_W  head word (IDLE_WORD when empty).
- out_ready  in  1  consumer pops head when out_valid&out_ready.
- overflow  out  1  sticky: push attempted while full with no same-cycle pop.
- underflow  out  1  sticky: out_ready asserted while empty.
- clear_flags  in  1  synchronous clear of overflow/underflow only.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, count = 0.
  - full = 0, almost_full = 0, out_valid = 0, out_data = IDLE_WORD.
  - overflow = 0, underflow = 0.
  - Storage contents are don't-care.
- Pointers are ADDR_W bits and wrap modulo depth. count is a separate ADDR_W+1 register, not derived from pointer difference.
- Define pop = out_valid & out_ready.
- Define push = wr_en & (~full | pop). A push into a full FIFO succeeds only when a pop happens in the same cycle.
- Per cycle, in this priority order:
  1. flush: pointers, count and both sticky flags go to 0. Same-cycle wr_en and out_ready are ignored: no push, no pop, no flag set.
  2. Otherwise, on push: mem[wr_ptr] <= wr_data; wr_ptr += 1.
  3. Otherwise, on pop: rd_ptr += 1.
  4. count update: push only +1; pop only -1; both or neither unchanged.
  5. overflow <= 1 when wr_en & full & ~pop.
  6. underflow <= 1 when out_ready & ~out_valid.
  7. clear_flags clears both sticky flags. A flag-set condition in the same cycle as clear_flags wins (flag reads 1 next cycle).
- Flags, status and output timing:
  - full, almost_full and out_valid are registered and derived from the next-state count, so they are consistent with count every cycle.
  - out_data = mem[rd_ptr] when out_valid, else IDLE_WORD. Storage may be distributed RAM with combinational read.
- Latency: a byte pushed into an empty FIFO at edge N appears with out_valid = 1 after edge N; a pop is possible at edge N+1. No bypass from wr_data to out_data in the same cycle.
- Simultaneous push and pop:
  - Empty: push only; pop is impossible because out_valid = 0, and underflow sets if out_ready is high.
  - Full: both occur, count stays at depth, full stays 1.
  - Otherwise both occur with count unchanged.
- Ordering: strict FIFO order across pointer wrap. Every accepted byte is popped exactly once unless flushed.
- Mid-operation events:
  - Reset asserted mid-operation: immediate return to reset state regardless of clk.
  - Flush mid-burst: discards all entries; the next push starts at index 0.

Test Plan:
- Reset, then push 8'hA5, 8'h3C on consecutive cycles with out_ready = 0 -> count = 2, out_valid = 1, out_data = 8'hA5; one pop -> out_data = 8'h3C, count = 1.
- Push 0x00..0x0F (16 bytes) -> full = 1 at count 16, almost_full from count 14. A 17th push of 0xFF -> overflow = 1, count stays 16, and popping all 16 yields 0x00..0x0F in order.
- Hold full with wr_en = 1, wr_data = 0x80 and out_ready = 1 for 20 cycles -> overflow stays 0, count stays 16, popped sequence continues 0x00..0x0F then 0x80 repeated. This exercises pointer wrap.
- Empty FIFO, out_ready = 1 for one cycle -> underflow = 1, out_data = IDLE_WORD, count = 0; clear_flags pulse -> underflow = 0.
- Load 5 bytes, then assert flush together with wr_en = 1 (0x77) and out_ready = 1 -> next cycle count = 0, out_valid = 0, flags 0, 0x77 not stored. A following push of 0x11 appears at out_data one cycle later.
- Drop rst_n asynchronously between clk edges with count = 9 and overflow = 1 -> outputs reach reset values before the next edge; after release, the first push of 0x42 behaves as in scenario 1.
